seq_shift_gen: RTL and testbench

SEQ_SHIFT_GEN -- requirements
Module: seq_shift_gen

---
 rtl/seq_shift_gen_if.sv | 15 +
 rtl/seq_shift_gen.sv | 85 ++++++++
 tb/tb_seq_shift_gen.sv | 108 ++++++++++
 3 files changed

// File: rtl/seq_shift_gen_if.sv
// seq_shift_gen_if: control inputs and sequence outputs of seq_shift_gen
// master drives button (raw push-button), load (strobe), load_data (parallel value);
// slave drives mode (0 ring, 1 Johnson, 2 LFSR, 3 hold), q (register), wrap (restart pulse)
interface seq_shift_gen_if #(
  parameter int WIDTH = 4
);
  logic button;
  logic load;
  logic [WIDTH-1:0] load_data;
  logic [1:0] mode;
  logic [WIDTH-1:0] q;
  logic wrap;
  modport master(output button, load, load_data, input mode, q, wrap);
  modport slave(input button, load, load_data, output mode, q, wrap);
endinterface

// File: rtl/seq_shift_gen.sv
// seq_shift_gen: debounced-button mode selector driving a ring/Johnson/LFSR/hold shift register
// clk, rst (sync active-high); bus: seq_shift_gen_if.slave (button, load, load_data in; mode, q, wrap out)
// SEQ_SELF_CORRECT_EN: when defined, ring/LFSR ticks from illegal states reload the seed
module seq_shift_gen #(
  parameter int WIDTH = 4,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int DIV = 1
) (
  input logic clk,
  input logic rst,
  seq_shift_gen_if.slave bus
);
  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int PW = $clog2(DIV + 1);
  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);
  // feedback taps as a bit mask, indexed by 0-based bit position
  localparam logic [7:0] TAPS = WIDTH == 3 ? 8'b0000_0110 :
                                WIDTH == 4 ? 8'b0000_1100 :
                                WIDTH == 5 ? 8'b0001_0100 :
                                WIDTH == 6 ? 8'b0011_0000 :
                                WIDTH == 7 ? 8'b0110_0000 : 8'b1011_1000;
  logic [1:0] sync;
  logic lvl, lvl_nxt, differ, settle, press, tick, fb, fix, wrap, wrap_nxt;
  logic [DW-1:0] db_cnt, db_nxt;
  logic [PW-1:0] pre, pre_nxt;
  logic [1:0] mode, mode_nxt, mode_inc;
  logic [WIDTH-1:0] q, q_nxt, step, cur_seed;

  function automatic logic [WIDTH-1:0] seed_of(input logic [1:0] m, input logic [WIDTH-1:0] cur);
    return m == 2'd1 ? '0 : m == 2'd3 ? cur : ONE;
  endfunction

  assign differ = sync[1] != lvl;
  assign settle = differ && db_cnt == DW'(DEBOUNCE_CYCLES - 1);
  assign press = settle && sync[1];
  assign tick = pre == PW'(DIV - 1);
  assign fb = ^(q & TAPS[WIDTH-1:0]);
  assign mode_inc = mode + 2'd1;
  assign cur_seed = seed_of(mode, q);

`ifdef SEQ_SELF_CORRECT_EN
  assign fix = (mode == 2'd0 && !$onehot(q)) || (mode == 2'd2 && q == '0);
`else
  assign fix = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      sync <= '0;
      lvl <= 1'b0;
      db_cnt <= '0;
      pre <= '0;
      mode <= '0;
      q <= ONE;
      wrap <= 1'b0;
    end else begin
      sync <= {sync[0], bus.button};
      lvl <= lvl_nxt;
      db_cnt <= db_nxt;
      pre <= pre_nxt;
      mode <= mode_nxt;
      q <= q_nxt;
      wrap <= wrap_nxt;
    end
  end

  // load beats press beats tick; a press (or tick) losing to load is dropped
  always_comb begin
    db_nxt = differ && !settle ? db_cnt + DW'(1) : '0;
    lvl_nxt = settle ? sync[1] : lvl;
    step = mode == 2'd3 ? q :
           fix ? cur_seed :
           {q[WIDTH-2:0], mode == 2'd0 ? q[WIDTH-1] : mode == 2'd1 ? ~q[WIDTH-1] : fb};
    pre_nxt = (!bus.load && press) || tick ? '0 : pre + PW'(1);
    mode_nxt = !bus.load && press ? mode_inc : mode;
    q_nxt = bus.load ? bus.load_data :
            press ? seed_of(mode_inc, q) :
            tick ? step : q;
    wrap_nxt = !bus.load && !press && tick && mode != 2'd3 && !fix && step == cur_seed;
  end

  assign bus.mode = mode;
  assign bus.q = q;
  assign bus.wrap = wrap;
endmodule

// File: tb/tb_seq_shift_gen.sv
// tb_seq_shift_gen: scoreboard bench for seq_shift_gen (W=4, DEBOUNCE_CYCLES=4, DIV=1)
module tb_seq_shift_gen;
  localparam int W = 4;
`ifdef SEQ_SELF_CORRECT_EN
  localparam logic SC = 1'b1;
`else
  localparam logic SC = 1'b0;
`endif
  typedef struct {
    string tag;
    logic [1:0] m;
    logic [W-1:0] q;
    logic w;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  exp_t sb[$];
  exp_t e;
  int checks = 0;
  int failures = 0;
  logic [W-1:0] rg[4] = '{4'b0010, 4'b0100, 4'b1000, 4'b0001};
  logic [W-1:0] jt[8] = '{4'b0001, 4'b0011, 4'b0111, 4'b1111, 4'b1110, 4'b1100, 4'b1000, 4'b0000};
  logic [W-1:0] lt[15] = '{4'b0010, 4'b0100, 4'b1001, 4'b0011, 4'b0110, 4'b1101, 4'b1010, 4'b0101,
                           4'b1011, 4'b0111, 4'b1111, 4'b1110, 4'b1100, 4'b1000, 4'b0001};
  logic [1:0] pm[4] = '{2'd1, 2'd2, 2'd3, 2'd0};
  logic [W-1:0] pq[4] = '{4'b0000, 4'b0001, 4'b1111, 4'b0001};

  seq_shift_gen_if #(.WIDTH(W)) bus();
  seq_shift_gen #(.WIDTH(W), .DEBOUNCE_CYCLES(4), .DIV(1)) dut(.clk(clk), .rst(rst), .bus(bus.slave));

  always #5 clk = ~clk;

  initial begin
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        checks++;
        if (bus.mode !== e.m || bus.q !== e.q || bus.wrap !== e.w) begin
          failures++;
          $display("FAIL %s: got mode=%0d q=%b wrap=%b, want mode=%0d q=%b wrap=%b",
                   e.tag, bus.mode, bus.q, bus.wrap, e.m, e.q, e.w);
        end
      end
    end
  end

  task automatic cyc(input string tag, input logic r, input logic b, input logic ld, input logic [W-1:0] d,
                     input logic chk, input logic [1:0] m, input logic [W-1:0] eq, input logic w);
    @(negedge clk);
    rst = r;
    bus.button = b;
    bus.load = ld;
    bus.load_data = d;
    @(posedge clk);
    if (chk) sb.push_back('{tag, m, eq, w});
  endtask

  task automatic tk(input string tag, input logic b, input logic chk, input logic [1:0] m,
                    input logic [W-1:0] eq, input logic w);
    cyc(tag, 1'b0, b, 1'b0, '0, chk, m, eq, w);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: bench did not complete");
    $fatal(1);
  end

  initial begin
    bus.button = 1'b0;
    bus.load = 1'b0;
    bus.load_data = '0;
    cyc("rst", 1'b1, 1'b0, 1'b0, '0, 1'b0, 2'd0, '0, 1'b0);
    cyc("rst", 1'b1, 1'b0, 1'b0, '0, 1'b1, 2'd0, 4'b0001, 1'b0);
    for (int i = 0; i < 10; i++) tk(i < 5 ? "ring" : "ring_debounce", i >= 5, 1'b1, 2'd0, rg[i % 4], i % 4 == 3);
    tk("press_johnson", 1'b1, 1'b1, 2'd1, 4'b0000, 1'b0);
    for (int k = 0; k < 21; k++)
      tk(k >= 10 && k < 16 ? "short_pulse" : "johnson", k < 4 || (k >= 10 && k < 12) || k >= 16,
         1'b1, 2'd1, jt[k % 8], k % 8 == 7);
    tk("press_lfsr", 1'b1, 1'b1, 2'd2, 4'b0001, 1'b0);
    for (int i = 0; i < 15; i++) tk("lfsr", 1'b0, 1'b1, 2'd2, lt[i], i == 14);
    for (int i = 0; i < 5; i++) tk("lfsr_pre", 1'b1, 1'b1, 2'd2, lt[i], 1'b0);
    cyc("load_over_press", 1'b0, 1'b1, 1'b1, 4'b0000, 1'b1, 2'd2, 4'b0000, 1'b0);
    tk("lfsr_zero_tick", 1'b1, 1'b1, 2'd2, SC ? 4'b0001 : 4'b0000, 1'b0);
    tk("lfsr_zero_tick2", 1'b1, 1'b1, 2'd2, SC ? 4'b0010 : 4'b0000, 1'b0);
    cyc("mid_rst", 1'b1, 1'b0, 1'b0, '0, 1'b0, 2'd0, '0, 1'b0);
    cyc("mid_rst", 1'b1, 1'b0, 1'b0, '0, 1'b1, 2'd0, 4'b0001, 1'b0);
    tk("post_rst", 1'b0, 1'b1, 2'd0, 4'b0010, 1'b0);
    cyc("ring_load", 1'b0, 1'b0, 1'b1, 4'b0110, 1'b1, 2'd0, 4'b0110, 1'b0);
    tk("ring_illegal_tick", 1'b0, 1'b1, 2'd0, SC ? 4'b0001 : 4'b1100, 1'b0);
    for (int p = 0; p < 4; p++) begin
      for (int i = 0; i < 5; i++) tk("hold_pre", 1'b1, p == 3, 2'd3, 4'b1111, 1'b0);
      tk("press_cycle", 1'b1, 1'b1, pm[p], pq[p], 1'b0);
      for (int i = 0; i < 6; i++) tk("hold", 1'b0, p == 2, 2'd3, 4'b1111, 1'b0);
    end
    @(negedge clk);
    @(negedge clk);
    if (sb.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL drain: got %0d pending, want 0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
